// File: rtl/multi_mode_mux_pkg.sv
// rtl/multi_mode_mux_pkg.sv - shared types, display-off constants and width helper for multi_mode_mux
package multi_mode_pkg;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_BLANK    = 2'd1,
    S_WAIT_REL = 2'd2
  } state_t;

  localparam logic [3:0] COM_OFF = 4'hF;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Index width for n values, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multi_mode_mux_pedge_det.sv
// rtl/multi_mode_mux_pedge_det.sv - per-bit rising-edge detector with one-cycle delay register
module pedge_det #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset_p,
  input  logic [W-1:0] d,
  output logic [W-1:0] pedge
);

  logic [W-1:0] d_q;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) d_q <= '0;
    else         d_q <= d;
  end

  assign pedge = d & ~d_q;

endmodule

// File: rtl/multi_mode_mux.sv
// rtl/multi_mode_mux.sv - front-panel mode arbiter: routes buttons/display/LEDs to the active app
// Optional MULTI_MODE_ALARM_FOCUS_EN: a rising alarm from an inactive app switches to that app.
module multi_mode_mux
  import multi_mode_pkg::*;
#(
  parameter int N_MODES    = 3,
  parameter int BTN_W      = 4,
  parameter int LED_W      = 4,
  parameter int BLANK_CYC  = 1000,
  parameter int RESET_MODE = 0
) (
  input  logic                               clk,
  input  logic                               reset_p,
  input  logic                               btn_mode,
  input  logic [BTN_W-1:0]                   btn,
  input  logic [4*N_MODES-1:0]               com_in,
  input  logic [8*N_MODES-1:0]               seg_in,
  input  logic [LED_W*N_MODES-1:0]           led_in,
  input  logic [N_MODES-1:0]                 alarm_in,
  output logic [BTN_W*N_MODES-1:0]           btn_out,
  output logic [3:0]                         com,
  output logic [7:0]                         seg_7,
  output logic [LED_W-1:0]                   led,
  output logic                               buzz,
  output logic [clog2_min1(N_MODES)-1:0]     mode
);

  localparam int MW = clog2_min1(N_MODES);
  localparam int CW = clog2_min1(BLANK_CYC);
  localparam logic [CW-1:0] CNT_LOAD   = (BLANK_CYC == 0) ? '0 : CW'(BLANK_CYC - 1);
  localparam logic [MW-1:0] LAST_MODE  = MW'(N_MODES - 1);
  localparam logic [MW-1:0] MODE_RESET = MW'(RESET_MODE);

  state_t                   state, state_nxt;
  logic [MW-1:0]            mode_nxt, mode_inc;
  logic [CW-1:0]            cnt, cnt_nxt;
  logic [3:0]               com_nxt;
  logic [7:0]               seg_nxt;
  logic [LED_W-1:0]         led_nxt;
  logic [BTN_W*N_MODES-1:0] btn_out_nxt;
  logic                     mode_pedge;
  logic                     switch_req;
  logic [MW-1:0]            switch_mode;
  logic                     focus_hit;
  logic [MW-1:0]            focus_idx;

  pedge_det #(.W(1)) u_mode_edge (
    .clk     (clk),
    .reset_p (reset_p),
    .d       (btn_mode),
    .pedge   (mode_pedge)
  );

`ifdef MULTI_MODE_ALARM_FOCUS_EN
  logic [N_MODES-1:0] alarm_pedge;

  pedge_det #(.W(N_MODES)) u_alarm_edge (
    .clk     (clk),
    .reset_p (reset_p),
    .d       (alarm_in),
    .pedge   (alarm_pedge)
  );

  // Descending scan so the lowest rising index is the one that sticks.
  always_comb begin
    focus_hit = 1'b0;
    focus_idx = '0;
    for (int i = N_MODES - 1; i >= 0; i--) begin
      if (alarm_pedge[i] && (MW'(i) != mode)) begin
        focus_hit = 1'b1;
        focus_idx = MW'(i);
      end
    end
  end
`else
  assign focus_hit = 1'b0;
  assign focus_idx = '0;
`endif

  assign mode_inc = (mode == LAST_MODE) ? '0 : mode + MW'(1);

  always_comb begin
    state_nxt   = state;
    mode_nxt    = mode;
    cnt_nxt     = cnt;
    com_nxt     = COM_OFF;
    seg_nxt     = SEG_OFF;
    led_nxt     = '0;
    btn_out_nxt = '0;
    switch_req  = 1'b0;
    switch_mode = mode_inc;

    case (state)
      S_RUN: begin
        com_nxt = com_in[4*int'(mode) +: 4];
        seg_nxt = seg_in[8*int'(mode) +: 8];
        led_nxt = led_in[LED_W*int'(mode) +: LED_W];
        btn_out_nxt[BTN_W*int'(mode) +: BTN_W] = btn;
        switch_req = mode_pedge;
      end
      S_BLANK: begin
        if (cnt == '0) state_nxt = S_WAIT_REL;
        else           cnt_nxt   = cnt - CW'(1);
      end
      S_WAIT_REL: begin
        com_nxt = com_in[4*int'(mode) +: 4];
        seg_nxt = seg_in[8*int'(mode) +: 8];
        led_nxt = led_in[LED_W*int'(mode) +: LED_W];
        if (mode_pedge)      switch_req = 1'b1;
        else if (btn == '0)  state_nxt  = S_RUN;
      end
      default: state_nxt = S_RUN;
    endcase

    if (focus_hit) begin
      switch_req  = 1'b1;
      switch_mode = focus_idx;
    end

    if (switch_req) begin
      mode_nxt = switch_mode;
      if (BLANK_CYC == 0) begin
        state_nxt = S_WAIT_REL;
      end else begin
        state_nxt = S_BLANK;
        cnt_nxt   = CNT_LOAD;
      end
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state   <= S_RUN;
      mode    <= MODE_RESET;
      cnt     <= '0;
      com     <= COM_OFF;
      seg_7   <= SEG_OFF;
      led     <= '0;
      btn_out <= '0;
      buzz    <= 1'b0;
    end else begin
      state   <= state_nxt;
      mode    <= mode_nxt;
      cnt     <= cnt_nxt;
      com     <= com_nxt;
      seg_7   <= seg_nxt;
      led     <= led_nxt;
      btn_out <= btn_out_nxt;
      buzz    <= |alarm_in;
    end
  end

endmodule

// File: tb/tb_multi_mode_mux.sv
// tb/tb_multi_mode_mux.sv - directed and randomized checks of multi_mode_mux against a cycle model
module tb_multi_mode_mux;

  localparam int N  = 3;
  localparam int BC = 4;

  logic        clk = 1'b0;
  logic        reset_p;
  logic        btn_mode;
  logic [3:0]  btn;
  logic [11:0] com_in;
  logic [23:0] seg_in;
  logic [11:0] led_in;
  logic [2:0]  alarm_in;
  logic [11:0] btn_out;
  logic [3:0]  com;
  logic [7:0]  seg_7;
  logic [3:0]  led;
  logic        buzz;
  logic [1:0]  mode;

  logic [3:0] a_com [N];
  logic [7:0] a_seg [N];
  logic [3:0] a_led [N];

  int n_cmp = 0;
  int n_err = 0;

  int          m_mode;
  int          blank_left;
  bit          holding;
  bit          prev_bm;
  logic [2:0]  prev_al;
  logic [3:0]  e_com;
  logic [7:0]  e_seg;
  logic [3:0]  e_led;
  logic [11:0] e_btn;
  logic        e_buzz;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      com_in[i*4 +: 4] = a_com[i];
      seg_in[i*8 +: 8] = a_seg[i];
      led_in[i*4 +: 4] = a_led[i];
    end
  end

  multi_mode_mux #(
    .N_MODES(N), .BTN_W(4), .LED_W(4), .BLANK_CYC(BC), .RESET_MODE(0)
  ) dut (
    .clk(clk), .reset_p(reset_p), .btn_mode(btn_mode), .btn(btn),
    .com_in(com_in), .seg_in(seg_in), .led_in(led_in), .alarm_in(alarm_in),
    .btn_out(btn_out), .com(com), .seg_7(seg_7), .led(led), .buzz(buzz), .mode(mode)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".mode"}, 32'(mode), 32'(m_mode));
    chk({tag, ".com"}, 32'(com), 32'(e_com));
    chk({tag, ".seg"}, 32'(seg_7), 32'(e_seg));
    chk({tag, ".led"}, 32'(led), 32'(e_led));
    chk({tag, ".btn_out"}, 32'(btn_out), 32'(e_btn));
    chk({tag, ".buzz"}, 32'(buzz), 32'(e_buzz));
  endtask

  task automatic model_reset();
    m_mode = 0; blank_left = 0; holding = 0; prev_bm = 0; prev_al = '0;
    e_com = 4'hF; e_seg = 8'hFF; e_led = '0; e_btn = '0; e_buzz = 1'b0;
  endtask

  task automatic switch_to(input int t);
    m_mode     = t;
    blank_left = BC;
    holding    = (BC == 0);
  endtask

  // Predicts the outputs after the next edge from the inputs currently applied.
  task automatic model_step();
    bit pe;
    int old;
    int tgt;
    pe  = btn_mode && !prev_bm;
    old = m_mode;
    tgt = -1;
    e_btn  = '0;
    e_buzz = |alarm_in;
    if (blank_left > 0) begin
      e_com = 4'hF; e_seg = 8'hFF; e_led = '0;
      blank_left--;
      if (blank_left == 0) holding = 1;
    end else begin
      e_com = a_com[old]; e_seg = a_seg[old]; e_led = a_led[old];
      if (!holding) e_btn[old*4 +: 4] = btn;
      if (pe) switch_to((old + 1) % N);
      else if (holding && btn == 0) holding = 0;
    end
`ifdef MULTI_MODE_ALARM_FOCUS_EN
    for (int i = N - 1; i >= 0; i--)
      if (alarm_in[i] && !prev_al[i] && i != old) tgt = i;
    if (tgt >= 0) switch_to(tgt);
`endif
    prev_bm = btn_mode;
    prev_al = alarm_in;
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic do_reset(input string tag);
    reset_p = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    reset_p = 1'b0;
  endtask

  task automatic pulse_mode(input string tag);
    btn_mode = 1'b1;
    tick(tag);
    btn_mode = 1'b0;
  endtask

  task automatic rand_apps();
    for (int i = 0; i < N; i++) begin
      a_com[i] = 4'($urandom);
      a_seg[i] = 8'($urandom);
      a_led[i] = 4'($urandom);
    end
  endtask

  initial begin
    reset_p = 1'b0; btn_mode = 1'b0; btn = '0; alarm_in = '0;
    rand_apps();
    model_reset();
    #2;

    // 1: reset and button routing to mode 0
    do_reset("t1.rst");
    btn = 4'b0101;
    tick("t1");
    chk("t1.btn_slice0", 32'(btn_out), 32'h005);
    chk("t1.com_slice0", 32'(com), 32'(a_com[0]));

    // 2: three switches with buttons released, wrap back to 0
    btn = '0;
    for (int k = 1; k <= 3; k++) begin
      pulse_mode("t2.pulse");
      ticks("t2", 4);
      chk("t2.dark", 32'(com), 32'hF);
      ticks("t2", 3);
      chk("t2.mode_seq", 32'(mode), 32'(k % N));
    end

    // 3: button held across a switch stays masked until released
    btn = 4'b0001;
    tick("t3");
    pulse_mode("t3.pulse");
    ticks("t3.held", 8);
    chk("t3.masked", 32'(btn_out), 32'h000);
    btn = '0;
    ticks("t3.rel", 2);
    btn = 4'b0001;
    ticks("t3.pass", 2);
    chk("t3.slice1", 32'(btn_out), 32'h010);
    btn = '0;
    tick("t3");

    // 4: pulse during blanking is ignored, pulse during release-wait is accepted
    btn = 4'b0010;
    pulse_mode("t4.pulse");
    tick("t4.blank");
    pulse_mode("t4.blank_pulse");
    ticks("t4.blank", 3);
    chk("t4.once", 32'(mode), 32'd2);
    pulse_mode("t4.wait_pulse");
    chk("t4.again", 32'(mode), 32'd0);
    ticks("t4.reblank", 3);
    chk("t4.reblank_dark", 32'(seg_7), 32'hFF);
    btn = '0;
    ticks("t4", 4);

    // 5: buzz pass-through; alarm focus when enabled
    do_reset("t5.rst");
    tick("t5");
    alarm_in = 3'b100;
    tick("t5.alarm");
    chk("t5.buzz", 32'(buzz), 32'd1);
    ticks("t5", 6);
    alarm_in = '0;
    ticks("t5", 6);
    do_reset("t5.rst2");
    tick("t5");
    alarm_in = 3'b110;
    ticks("t5.dual", 8);
    alarm_in = '0;
    tick("t5");

    // 6: asynchronous reset in the second blanking cycle
    do_reset("t6.rst");
    tick("t6");
    pulse_mode("t6.pulse");
    tick("t6.blank2");
    reset_p = 1'b1;
    #1;
    model_reset();
    check_all("t6.async");
    @(negedge clk);
    reset_p = 1'b0;

    // random traffic
    for (int c = 0; c < 600; c++) begin
      rand_apps();
      btn      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      btn_mode = ($urandom_range(0, 5) == 0);
      alarm_in = ($urandom_range(0, 7) == 0) ? 3'($urandom) : alarm_in;
      tick("rand");
      if (c == 300) do_reset("rand.rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
